// File: rtl/bus_share_arbiter_if.sv
// Shared-bus bundle between the two requesters and the round-robin arbiter.
// The master side is the arbiter, which owns grants, enables, select and the bus value.
interface bus_share_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [1:0]       gnt;
    logic             en0;
    logic             en1;
    logic             s;
    logic [WIDTH-1:0] y;
    logic             preempt;

    modport master (
        input  req, d0, d1,
        output gnt, en0, en1, s, y, preempt
    );

    modport slave (
        output req, d0, d1,
        input  gnt, en0, en1, s, y, preempt
    );
endinterface

// File: rtl/bus_share_arbiter.sv
// Two-requester round-robin arbiter for one shared bus, with a one-cycle turnaround
// between owners and a hold limit that forces release after MAX_HOLD granted cycles.
module bus_share_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                reset,
    bus_share_arbiter_if.master bus
);
    localparam int             CW        = $clog2(MAX_HOLD);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, TURN} state_t;

    state_t           state;
    logic             last;
    logic [CW-1:0]    hold_cnt;
    logic [1:0]       gnt_q;
    logic             s_q;
    logic             preempt_q;

    logic             pick;
    logic             owner;
    logic             release_now;
    logic [WIDTH-1:0] y_mux;

    // NOTE: every always_comb output gets a value on every path; a missed branch would infer a latch.
    always_comb begin
        pick        = bus.req[1] & (~bus.req[0] | ~last);
        owner       = (state == GNT1);
        release_now = ~bus.req[owner] | (hold_cnt == HOLD_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt_q     <= '0;
            s_q       <= 1'b0;
            preempt_q <= 1'b0;
            last      <= 1'b1;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    preempt_q <= 1'b0;
                    hold_cnt  <= '0;
                    if (|bus.req) begin
                        state <= pick ? GNT1 : GNT0;
                        gnt_q <= pick ? 2'b10 : 2'b01;
                        s_q   <= pick;
                    end else begin
                        state <= IDLE;
                        gnt_q <= '0;
                    end
                end
                GNT0, GNT1: begin
                    if (release_now) begin
                        state     <= TURN;
                        gnt_q     <= '0;
                        last      <= owner;
                        hold_cnt  <= '0;
                        // A still-asserted request at release means the limit forced it.
                        preempt_q <= bus.req[owner];
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        y_mux = '0;
        if (gnt_q[0])      y_mux = bus.d0;
        else if (gnt_q[1]) y_mux = bus.d1;
    end

    assign bus.gnt     = gnt_q;
    assign bus.en0     = gnt_q[0];
    assign bus.en1     = gnt_q[1];
    assign bus.s       = s_q;
    assign bus.preempt = preempt_q;
    assign bus.y       = y_mux;
endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed and random-pattern bench for bus_share_arbiter with MAX_HOLD=4.
// Observed word per cycle: {gnt, en1, en0, s, preempt, y}.
module tb_bus_share_arbiter;
    localparam int W  = 4;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    bus_share_arbiter_if #(.WIDTH(W)) bus ();

    bus_share_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] obs();
        return {bus.gnt, bus.en1, bus.en0, bus.s, bus.preempt, bus.y};
    endfunction

    function automatic logic [9:0] mk(input logic [1:0] g, input logic s,
                                      input logic p, input logic [3:0] y);
        return {g, g[1], g[0], s, p, y};
    endfunction

    task automatic tick(input logic [1:0] r);
        bus.req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bus.req = 2'b00;
        bus.d0  = 4'h3;
        bus.d1  = 4'hC;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs() !== 10'h000) begin
            bad++;
            $display("FAIL reset: got %h want %h", obs(), 10'h000);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0] rq [5];
        logic [9:0] ex [5];
        rq = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        ex = '{mk(2'b01, 0, 0, 4'h3), mk(2'b01, 0, 0, 4'h3), mk(2'b01, 0, 0, 4'h3),
               mk(2'b00, 0, 0, 4'h0), mk(2'b00, 0, 0, 4'h0)};
        for (int i = 0; i < 5; i++) begin
            tick(rq[i]);
            total++;
            if (obs() !== ex[i]) begin
                bad++;
                $display("FAIL single[%0d]: got %h want %h", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_alternate();
        logic [1:0] rq [10];
        logic [9:0] ex [10];
        do_reset();
        bus.d0 = 4'hA;
        bus.d1 = 4'h5;
        rq = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
        ex = '{mk(2'b01, 0, 0, 4'hA), mk(2'b01, 0, 0, 4'hA), mk(2'b00, 0, 0, 4'h0),
               mk(2'b10, 1, 0, 4'h5), mk(2'b10, 1, 0, 4'h5), mk(2'b00, 1, 0, 4'h0),
               mk(2'b01, 0, 0, 4'hA), mk(2'b01, 0, 0, 4'hA), mk(2'b00, 0, 0, 4'h0),
               mk(2'b00, 0, 0, 4'h0)};
        for (int i = 0; i < 10; i++) begin
            tick(rq[i]);
            total++;
            if (obs() !== ex[i]) begin
                bad++;
                $display("FAIL alternate[%0d]: got %h want %h", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_preempt_single();
        logic [9:0] e;
        bus.d0 = 4'h6;
        for (int k = 1; k <= 14; k++) begin
            tick(2'b01);
            e = (k % 5 == 0) ? mk(2'b00, 0, 1, 4'h0) : mk(2'b01, 0, 0, 4'h6);
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL preempt_single[%0d]: got %h want %h", k, obs(), e);
            end
        end
        // Request drops in the expiry cycle: TURN without preempt.
        tick(2'b00);
        total++;
        if (obs() !== mk(2'b00, 0, 0, 4'h0)) begin
            bad++;
            $display("FAIL expiry_drop: got %h want %h", obs(), mk(2'b00, 0, 0, 4'h0));
        end
        tick(2'b00);
        total++;
        if (obs() !== mk(2'b00, 0, 0, 4'h0)) begin
            bad++;
            $display("FAIL expiry_idle: got %h want %h", obs(), mk(2'b00, 0, 0, 4'h0));
        end
    endtask

    task automatic test_preempt_both();
        logic [9:0] e;
        int         m;
        do_reset();
        bus.d0 = 4'h6;
        bus.d1 = 4'h9;
        for (int k = 1; k <= 15; k++) begin
            tick(2'b11);
            m = k % 10;
            if (m >= 1 && m <= 4)      e = mk(2'b01, 0, 0, 4'h6);
            else if (m == 5)           e = mk(2'b00, 0, 1, 4'h0);
            else if (m >= 6 && m <= 9) e = mk(2'b10, 1, 0, 4'h9);
            else                       e = mk(2'b00, 1, 1, 4'h0);
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL preempt_both[%0d]: got %h want %h", k, obs(), e);
            end
        end
        tick(2'b00);
        total++;
        if (obs() !== mk(2'b00, 0, 0, 4'h0)) begin
            bad++;
            $display("FAIL both_idle: got %h want %h", obs(), mk(2'b00, 0, 0, 4'h0));
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            tick(2'b10);
            total++;
            if (obs() !== mk(2'b10, 1, 0, 4'h9)) begin
                bad++;
                $display("FAIL mid_grant[%0d]: got %h want %h", i, obs(), mk(2'b10, 1, 0, 4'h9));
            end
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (obs() !== mk(2'b00, 0, 0, 4'h0)) begin
            bad++;
            $display("FAIL async_reset: got %h want %h", obs(), mk(2'b00, 0, 0, 4'h0));
        end
        bus.req = 2'b11;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (obs() !== mk(2'b01, 0, 0, 4'h6)) begin
            bad++;
            $display("FAIL post_reset_tie: got %h want %h", obs(), mk(2'b01, 0, 0, 4'h6));
        end
    endtask

    task automatic test_random();
        logic [1:0] prev = 2'b00;
        logic [3:0] exp_y;
        int         run  = 0;
        for (int i = 0; i < 300; i++) begin
            bus.d0 = W'($urandom);
            bus.d1 = W'($urandom);
            tick(2'($urandom_range(0, 3)));
            exp_y = (bus.gnt == 2'b01) ? bus.d0 : (bus.gnt == 2'b10) ? bus.d1 : 4'h0;
            total++;
            if (bus.gnt === 2'b11 || (bus.en0 & bus.en1)) begin
                bad++;
                $display("FAIL onehot[%0d]: got gnt=%b en=%b%b want not both", i, bus.gnt, bus.en1, bus.en0);
            end
            total++;
            if ({bus.en1, bus.en0} !== bus.gnt) begin
                bad++;
                $display("FAIL enables[%0d]: got %b%b want %b", i, bus.en1, bus.en0, bus.gnt);
            end
            total++;
            if (bus.y !== exp_y) begin
                bad++;
                $display("FAIL y[%0d]: got %h want %h", i, bus.y, exp_y);
            end
            total++;
            if (prev != 2'b00 && bus.gnt != 2'b00 && bus.gnt != prev) begin
                bad++;
                $display("FAIL turnaround[%0d]: got %b after %b want 00 between", i, bus.gnt, prev);
            end
            run = (bus.gnt != 2'b00 && bus.gnt == prev) ? run + 1 : ((bus.gnt != 2'b00) ? 1 : 0);
            total++;
            if (run > MH) begin
                bad++;
                $display("FAIL hold_len[%0d]: got %0d want <= %0d", i, run, MH);
            end
            prev = bus.gnt;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_preempt_single();
        test_preempt_both();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_share_arbiter.md
Name: bus_share_arbiter

Overview:
Two-requester round-robin arbiter that time-shares one 4-bit shared bus built from a 2:1 mux or a pair of tristate drivers. It issues registered grants and drives the mux select and the per-driver tristate enables. A mandatory one-cycle turnaround between owners prevents bus contention. A hold limit forces release so neither requester can starve the other.

Parameters:
WIDTH, 4, data width of the shared bus
MAX_HOLD, 8, maximum consecutive granted cycles per tenure (legal range: 2 or more)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req  input  2  req[i]=1: requester i wants the bus
d0  input  WIDTH  requester 0 data
d1  input  WIDTH  requester 1 data
gnt  output  2  one-hot-or-zero grant, registered
en0  output  1  tristate enable for driver 0 (equals gnt[0])
en1  output  1  tristate enable for driver 1 (equals gnt[1])
s  output  1  mux select: 1 = d1, 0 = d0; holds the last granted index
y  output  WIDTH  bus value: d0 if gnt[0], d1 if gnt[1], else 0
preempt  output  1  one-cycle pulse in the TURN cycle that follows a forced release

Behaviour:
- Reset is asynchronous.
  - Effects: state=IDLE, gnt=0, en0=en1=0, s=0, preempt=0, last=1, hold_cnt=0. y becomes 0 immediately.
  - Because last=1 out of reset, requester 0 wins the first tie.
  - Reset asserted mid-tenure drops the grant the same instant, with no TURN cycle.
- States: IDLE, GNT0, GNT1, TURN.
- Arbitration (evaluated in IDLE and TURN):
  - Only req[0] high: next state GNT0.
  - Only req[1] high: next state GNT1.
  - Both high: grant the index != last.
  - Neither high: next state IDLE.
- Latency: req sampled high in IDLE at edge t gives gnt high after edge t. y and enables are valid in that same cycle.
- GNTi (i = 0 or 1):
  - hold_cnt increments each cycle from 0.
  - Stay in GNTi while req[i]=1 and hold_cnt < MAX_HOLD-1.
  - Go to TURN and set last=i when req[i]=0, or when hold_cnt = MAX_HOLD-1 (forced release).
  - Forced release sets preempt=1 for the TURN cycle. If req[i] drops exactly in the expiry cycle, preempt=0.
  - hold_cnt resets to 0 on leaving GNTi.
  - Maximum grant width is MAX_HOLD cycles.
- TURN:
  - Exactly one cycle with gnt=0 and both enables low, so the bus floats.
  - Arbitration runs in TURN; the next owner's grant appears in the cycle after TURN.
  - A sole requester may regain the bus after TURN, including after preemption.
- s:
  - Updates to i on entry to GNTi.
  - Unchanged in IDLE and TURN.
- Invariants:
  - gnt never equals 2'b11.
  - en0 and en1 are never both 1.
  - Owners never switch without an intervening TURN cycle.
- y is combinational from gnt and d0/d1. With no grant, y = 0, never X.
- hold_cnt width is $clog2(MAX_HOLD). No wrap occurs, because the counter never exceeds MAX_HOLD-1.
- req changes while already granted have no effect until the next arbitration point.

Test Plan:
- Reset, then req=01 at cycle 2 and held 3 cycles, then dropped → gnt=01, en0=1, s=0 for 3 cycles; then 1 TURN cycle with gnt=00, then IDLE; y=d0 while granted, 0 otherwise.
- req=11 from reset with d0=4'hA, d1=4'h5, each requester dropping its req after 2 granted cycles and re-asserting it one cycle later → grants alternate 0 then 1 then 0; y toggles A→0→5→0; each owner change is separated by exactly one 00 cycle.
- MAX_HOLD=4, req=01 held continuously → gnt[0] high 4 cycles; TURN with preempt=1; gnt[0] reasserted next cycle; pattern repeats every 5 cycles.
- MAX_HOLD=4, req=11 held continuously → GNT0 for 4 cycles, TURN with preempt=1, GNT1 for 4 cycles, TURN with preempt=1, and so on; s alternates 0/1.
- req=10 granted, reset asserted mid-cycle 2 of the tenure → gnt, en1 and y go to 0 asynchronously. After release with req=11, requester 0 is granted first.
- Every cycle of a randomized req pattern → assert gnt!=11, en0&en1==0, no owner change without a TURN cycle, and no grant longer than MAX_HOLD cycles.
